// File: rtl/ldpc_3gpp_enc_mm_mbram_pkg.sv
// ldpc_3gpp_enc_mm_mbram_pkg: shared types and helpers for the multi-bank LDPC matrix multiplier
//   mm_rflag_t : per-read-command direction/mask flags carried down the data pipeline
//   mm_bs_w()  : width of the in-word bit-shift field (at least 1 bit, so the port exists for pDAT_W=1)
package ldpc_3gpp_enc_mm_mbram_pkg;

  typedef struct packed {
    logic shift_r;
    logic masked;
  } mm_rflag_t;

  function automatic int mm_bs_w(input int dat_w);
    return (dat_w > 1) ? $clog2(dat_w) : 1;
  endfunction

endpackage

// File: rtl/ldpc_3gpp_enc_mm_addr_gen.sv
// ldpc_3gpp_enc_mm_addr_gen: wrapping word-address counter with a registered early-wrap flag
//   iclk, iclkena     : clock and clock enable (low freezes the counter)
//   istart, iload     : start a pass; the current address is iload this cycle
//   istep             : consume the current address; the next one follows on the following cycle
//   iused_zc          : words per Zc; the address wraps to 0 after iused_zc-1
//   oaddr             : address for the current cycle
module ldpc_3gpp_enc_mm_addr_gen
  import ldpc_3gpp_enc_mm_mbram_pkg::*;
#(
  parameter int pADDR_W = 8
) (
  input  logic               iclk,
  input  logic               iclkena,
  input  logic               istart,
  input  logic               istep,
  input  logic [pADDR_W-1:0] iload,
  input  logic [pADDR_W:0]   iused_zc,
  output logic [pADDR_W-1:0] oaddr
);

  logic [pADDR_W-1:0] addr_q, addr_d;
  logic               wrap_q, wrap_d, cur_wrap;

  // wrap_q says "addr_q is the last word", precomputed one step early against iused_zc-2
  always_comb begin
    oaddr    = istart ? iload : addr_q;
    cur_wrap = istart ? ({1'b0, iload} == iused_zc - (pADDR_W+1)'(1)) : wrap_q;
    addr_d   = cur_wrap ? '0 : oaddr + pADDR_W'(1);
    wrap_d   = !cur_wrap && ({1'b0, oaddr} == iused_zc - (pADDR_W+1)'(2));
  end

  always_ff @(posedge iclk)
    if (iclkena && (istart || istep)) begin
      addr_q <= istep ? addr_d : oaddr;
      wrap_q <= istep ? wrap_d : cur_wrap;
    end

endmodule

// File: rtl/ldpc_3gpp_enc_mm_mbram.sv
// ldpc_3gpp_enc_mm_mbram: multi-bank Zc storage with per-command cyclic shift on read
//   write : iwrite/iwstart/iwbank/iwdat store one word per cycle into a bank
//   read  : iread/irstart/irbank/irwshift/irbshift/irshift_r/irmasked issue one shifted pass
//   tags  : irval/irstrb are delayed to oval/ostrb, aligned with odat
//   ocollision : sticky flag, write and read hit the same bank in one cycle
//   iused_zc : words per Zc; iclkena low freezes everything; ireset async active-high
// Optional macro LDPC_3GPP_ENC_MM_MBRAM_PIPE_EN adds a register after the RAM output (latency 4 vs 3).
module ldpc_3gpp_enc_mm_mbram
  import ldpc_3gpp_enc_mm_mbram_pkg::*;
#(
  parameter int pADDR_W = 8,
  parameter int pDAT_W  = 8,
  parameter int pBANK_N = 2,
  parameter int pSTRB_W = 4
) (
  input  logic                         iclk,
  input  logic                         ireset,
  input  logic                         iclkena,
  input  logic [pADDR_W:0]             iused_zc,
  input  logic                         iwrite,
  input  logic                         iwstart,
  input  logic [$clog2(pBANK_N)-1:0]   iwbank,
  input  logic [pDAT_W-1:0]            iwdat,
  input  logic                         iread,
  input  logic                         irstart,
  input  logic [$clog2(pBANK_N)-1:0]   irbank,
  input  logic [pADDR_W-1:0]           irwshift,
  input  logic [mm_bs_w(pDAT_W)-1:0]   irbshift,
  input  logic                         irshift_r,
  input  logic                         irmasked,
  input  logic                         irval,
  input  logic [pSTRB_W-1:0]           irstrb,
  output logic                         oval,
  output logic [pSTRB_W-1:0]           ostrb,
  output logic [pDAT_W-1:0]            odat,
  output logic                         ocollision
);

  localparam int BK_W = $clog2(pBANK_N);
  localparam int BS_W = mm_bs_w(pDAT_W);
`ifdef LDPC_3GPP_ENC_MM_MBRAM_PIPE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct packed {
    logic [BS_W-1:0] bshift;
    mm_rflag_t       f;
  } rcmd_t;

  logic [pDAT_W-1:0]              ram [2**(BK_W+pADDR_W)];
  logic [BK_W-1:0]                wbank_q, rbank_q, wbank, rbank;
  logic [pADDR_W-1:0]             waddr, raddr, rload;
  logic [BK_W+pADDR_W-1:0]        waddr_q, raddr_q;
  logic [pDAT_W-1:0]              wdat_q, rdat_q, prev_q, cur, odat_q, odat_d;
  logic                           we_q, col_q, col_d;
  rcmd_t                          cmd_q, cmd_a_q, cmd;
  logic [BS_W-1:0]                b;
  logic [LAT-1:0]                 val_q;
  logic [LAT-1:0][pSTRB_W-1:0]    strb_q;

  assign wbank = iwstart ? iwbank : wbank_q;
  assign rbank = irstart ? irbank : rbank_q;
  // right shift walks the same ascending order, just starting Zc-1-wshift words in
  assign rload = irshift_r ? pADDR_W'(iused_zc - (pADDR_W+1)'(1) - {1'b0, irwshift}) : irwshift;

  ldpc_3gpp_enc_mm_addr_gen #(.pADDR_W(pADDR_W)) u_wgen (
    .iclk     (iclk),
    .iclkena  (iclkena),
    .istart   (iwstart),
    .istep    (iwrite),
    .iload    ('0),
    .iused_zc (iused_zc),
    .oaddr    (waddr)
  );

  ldpc_3gpp_enc_mm_addr_gen #(.pADDR_W(pADDR_W)) u_rgen (
    .iclk     (iclk),
    .iclkena  (iclkena),
    .istart   (irstart),
    .istep    (iread),
    .iload    (rload),
    .iused_zc (iused_zc),
    .oaddr    (raddr)
  );

  // storage and datapath: no reset, RAM contents and counters survive ireset
  always_ff @(posedge iclk)
    if (iclkena) begin
      if (iwstart) wbank_q <= iwbank;
      if (irstart) begin
        rbank_q <= irbank;
        cmd_q   <= {irbshift, irshift_r, irmasked};
      end
      waddr_q <= {wbank, waddr};
      wdat_q  <= iwdat;
      if (we_q) ram[waddr_q] <= wdat_q;
      raddr_q <= {rbank, raddr};
      rdat_q  <= ram[raddr_q];
      cmd_a_q <= cmd_q;
      prev_q  <= cur;
    end

`ifdef LDPC_3GPP_ENC_MM_MBRAM_PIPE_EN
  logic [pDAT_W-1:0] rdat_p_q;
  rcmd_t             cmd_p_q;
  always_ff @(posedge iclk)
    if (iclkena) begin
      rdat_p_q <= rdat_q;
      cmd_p_q  <= cmd_a_q;
    end
  assign cur = rdat_p_q;
  assign cmd = cmd_p_q;
`else
  assign cur = rdat_q;
  assign cmd = cmd_a_q;
`endif

  // cur is the newer word; the pair {cur,prev} spans the output word for either direction
  always_comb begin
    b      = (pDAT_W > 1) ? cmd.bshift : '0;
    odat_d = cmd.f.masked  ? '0 :
             cmd.f.shift_r ? pDAT_W'(({cur, prev_q} << b) >> pDAT_W) :
                             pDAT_W'({cur, prev_q} >> b);
    col_d  = col_q | (iwrite & iread & (wbank == rbank));
  end

  always_ff @(posedge iclk or posedge ireset)
    if (ireset) begin
      we_q   <= 1'b0;
      val_q  <= '0;
      strb_q <= '0;
      odat_q <= '0;
      col_q  <= 1'b0;
    end else if (iclkena) begin
      we_q   <= iwrite;
      val_q  <= {val_q[LAT-2:0], irval};
      strb_q <= {strb_q[LAT-2:0], irstrb};
      odat_q <= odat_d;
      col_q  <= col_d;
    end

  assign oval       = val_q[LAT-1];
  assign ostrb      = strb_q[LAT-1];
  assign odat       = odat_q;
  assign ocollision = col_q;

endmodule

// File: tb/tb_ldpc_3gpp_enc_mm_mbram.sv
// tb_ldpc_3gpp_enc_mm_mbram: directed vector bench for the multi-bank shifting store
module tb_ldpc_3gpp_enc_mm_mbram;

`ifdef LDPC_3GPP_ENC_MM_MBRAM_PIPE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       iclk = 1'b0, ireset = 1'b1, iclkena = 1'b1;
  logic [8:0] iused_zc = 9'd4;
  logic       iwrite = 1'b0, iwstart = 1'b0;
  logic [0:0] iwbank = '0;
  logic [7:0] iwdat = '0;
  logic       iread = 1'b0, irstart = 1'b0;
  logic [0:0] irbank = '0;
  logic [7:0] irwshift = '0;
  logic [2:0] irbshift = '0;
  logic       irshift_r = 1'b0, irmasked = 1'b0, irval = 1'b0;
  logic [3:0] irstrb = '0;
  logic       oval, ocollision;
  logic [3:0] ostrb;
  logic [7:0] odat;

  int n_vec = 0, n_fail = 0, cyc = 0;
  logic [11:0] q[$];

  typedef struct {
    logic [0:0]  bank;
    logic [7:0]  ws;
    logic [2:0]  bs;
    logic        r;
    logic        m;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[8];

  ldpc_3gpp_enc_mm_mbram dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iused_zc(iused_zc),
    .iwrite(iwrite), .iwstart(iwstart), .iwbank(iwbank), .iwdat(iwdat),
    .iread(iread), .irstart(irstart), .irbank(irbank), .irwshift(irwshift),
    .irbshift(irbshift), .irshift_r(irshift_r), .irmasked(irmasked),
    .irval(irval), .irstrb(irstrb),
    .oval(oval), .ostrb(ostrb), .odat(odat), .ocollision(ocollision)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;
  // one entry per output word actually consumed (frozen cycles are not re-counted)
  always @(negedge iclk) if (oval && iclkena) q.push_back({ostrb, odat});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    do @(posedge iclk); while (!iclkena);
    #1;
  endtask

  task automatic write_bank(input logic [0:0] bk, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      iwrite = 1'b1; iwstart = (i == 0); iwbank = bk; iwdat = d[8*i +: 8];
      tick();
    end
    iwrite = 1'b0; iwstart = 1'b0;
  endtask

  task automatic read_cmd(input logic [0:0] bk, input logic [7:0] ws, input logic [2:0] bs,
                          input logic r, input logic m);
    iread = 1'b1; irstart = 1'b1; irbank = bk; irwshift = ws; irbshift = bs;
    irshift_r = r; irmasked = m; irval = 1'b0; irstrb = '0;
    tick();
    irstart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      irval = 1'b1; irstrb = (i == 0) ? 4'd1 : (i == 3) ? 4'd2 : 4'd0;
      tick();
    end
  endtask

  task automatic idle_rd();
    iread = 1'b0; irval = 1'b0; irstrb = '0;
  endtask

  task automatic check_read(input string nm, input logic [31:0] exp);
    int k;
    logic [11:0] w;
    k = 0;
    while (q.size() < 4 && k < 50) begin @(negedge iclk); #1; k++; end
    if (q.size() < 4) begin
      n_vec++; n_fail++;
      $display("FAIL %s timeout: got %0d words want 4", nm, q.size());
      q.delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        w = q.pop_front();
        chk($sformatf("%s dat%0d", nm, i), {24'd0, w[7:0]}, {24'd0, exp[8*i +: 8]});
        chk($sformatf("%s strb%0d", nm, i), {28'd0, w[11:8]}, (i == 0) ? 32'd1 : (i == 3) ? 32'd2 : 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 8'd0, 3'd4, 1'b0, 1'b0, 32'h18765432};
    vt[1] = '{1'b0, 8'd1, 3'd0, 1'b0, 1'b0, 32'h21876543};
    vt[2] = '{1'b0, 8'd1, 3'd0, 1'b1, 1'b0, 32'h65432187};
    vt[3] = '{1'b0, 8'd1, 3'd4, 1'b0, 1'b1, 32'h00000000};
    vt[4] = '{1'b0, 8'd0, 3'd4, 1'b1, 1'b0, 32'h76543218};
    vt[5] = '{1'b0, 8'd2, 3'd4, 1'b0, 1'b0, 32'h54321876};
    vt[6] = '{1'b0, 8'd3, 3'd4, 1'b1, 1'b0, 32'h18765432};
    vt[7] = '{1'b0, 8'd0, 3'd0, 1'b0, 1'b0, 32'h87654321};

    repeat (2) @(posedge iclk);
    #1;
    chk("rst oval", {31'd0, oval}, 0);
    chk("rst ostrb", {28'd0, ostrb}, 0);
    chk("rst odat", {24'd0, odat}, 0);
    chk("rst col", {31'd0, ocollision}, 0);
    ireset = 1'b0;
    tick();

    write_bank(1'b0, 32'h87654321);
    tick();
    for (int i = 0; i < 8; i++) begin
      read_cmd(vt[i].bank, vt[i].ws, vt[i].bs, vt[i].r, vt[i].m);
      idle_rd();
      check_read($sformatf("vec%0d", i), vt[i].exp);
    end

    // ping-pong: fill bank1 while reading bank0, then read bank1 back-to-back
    fork
      write_bank(1'b1, 32'hD4C3B2A1);
      read_cmd(1'b0, 8'd0, 3'd4, 1'b0, 1'b0);
    join
    read_cmd(1'b1, 8'd0, 3'd0, 1'b0, 1'b0);
    idle_rd();
    check_read("pp bank0", 32'h18765432);
    check_read("pp bank1", 32'hD4C3B2A1);
    chk("pp col", {31'd0, ocollision}, 0);

    // irval to oval latency, data unchanged
    fork
      read_cmd(1'b0, 8'd0, 3'd0, 1'b0, 1'b0);
      begin
        int k, ci;
        k = 0;
        while (!irval && k < 20) begin @(negedge iclk); k++; end
        ci = cyc;
        while (!oval && k < 40) begin @(negedge iclk); k++; end
        chk("latency", cyc - ci, LAT);
      end
    join
    idle_rd();
    check_read("lat data", 32'h87654321);

    // clock enable low for three cycles in the middle of a read
    fork
      read_cmd(1'b0, 8'd1, 3'd0, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge iclk);
        #1 iclkena = 1'b0;
        repeat (3) @(posedge iclk);
        #1 iclkena = 1'b1;
      end
    join
    idle_rd();
    check_read("freeze", 32'h21876543);

    // same-bank write and read in one cycle
    fork
      write_bank(1'b0, 32'h87654321);
      read_cmd(1'b0, 8'd0, 3'd0, 1'b0, 1'b0);
      begin
        tick();
        chk("col next", {31'd0, ocollision}, 1);
      end
    join
    idle_rd();
    repeat (LAT + 3) tick();
    chk("col sticky", {31'd0, ocollision}, 1);
    q.delete();

    // reset in the middle of a read
    fork
      read_cmd(1'b0, 8'd0, 3'd4, 1'b0, 1'b0);
      begin
        repeat (5) @(posedge iclk);
        #2;
        chk("pre rst oval", {31'd0, oval}, 1);
        ireset = 1'b1;
        #1;
        chk("mid rst oval", {31'd0, oval}, 0);
        chk("mid rst odat", {24'd0, odat}, 0);
        chk("mid rst col", {31'd0, ocollision}, 0);
      end
    join
    idle_rd();
    tick();
    ireset = 1'b0;
    q.delete();
    tick();
    read_cmd(1'b0, 8'd0, 3'd4, 1'b0, 1'b0);
    idle_rd();
    check_read("reread", 32'h18765432);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
